// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ sources  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 13 * CLKS_PER_BIT,
  parameter int GAP_CLKS     = 2,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic                 o_Err,
  output logic [IDW-1:0]       o_Err_Id,
  output logic                 o_Busy,
  output logic [IDW-1:0]       o_Grant_Id,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int GW = $clog2(GAP_CLKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [IDW-1:0]       ptr, ptr_next;
  logic [IDW-1:0]       grant_next;
  logic [7:0]           byte_next;
  logic                 dv, dv_next;
  logic [TW-1:0]        timer, timer_next;
  logic [GW-1:0]        gap_cnt, gap_next;
  logic [NUM_REQ-1:0]   ack_next, done_next;
  logic                 err_next;
  logic [IDW-1:0]       err_id_next;
  logic                 pick_valid;
  logic [IDW-1:0]       pick_id;
  logic [7:0]           req_bytes [NUM_REQ];
  logic                 unused_tx_active;

  // Transmitter activity is informational only; sequencing relies on i_Tx_Done.
  assign unused_tx_active = i_Tx_Active;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = i_Req_Byte[8*k +: 8];
  end

  // Descending scan so the lowest offset from ptr+1 is the last (winning) write.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_Req[IDW'(idx)]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    grant_next  = o_Grant_Id;
    byte_next   = o_Tx_Byte;
    dv_next     = dv;
    timer_next  = timer;
    gap_next    = gap_cnt;
    ack_next    = '0;
    done_next   = '0;
    err_next    = 1'b0;
    err_id_next = o_Err_Id;
    case (state)
      S_IDLE: begin
        dv_next = 1'b0;
        if (pick_valid) begin
          byte_next          = req_bytes[pick_id];
          grant_next         = pick_id;
          ptr_next           = pick_id;
          ack_next[pick_id]  = 1'b1;
          timer_next         = '0;
          dv_next            = 1'b1;
          state_next         = S_SEND;
        end
      end
      S_SEND: begin
        // Completion takes precedence over a coincident timeout.
        if (i_Tx_Done) begin
          done_next[o_Grant_Id] = 1'b1;
          timer_next            = '0;
          gap_next              = '0;
          dv_next               = 1'b0;
          state_next            = S_GAP;
        end else if (timer == TW'(TIMEOUT_CLKS - 1)) begin
          err_next    = 1'b1;
          err_id_next = o_Grant_Id;
          timer_next  = '0;
          gap_next    = '0;
          dv_next     = 1'b0;
          state_next  = S_GAP;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      S_GAP: begin
        dv_next = 1'b0;
        if (gap_cnt == GW'(GAP_CLKS - 1)) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      default: begin
        dv_next    = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= S_IDLE;
      ptr        <= IDW'(NUM_REQ - 1);
      o_Grant_Id <= '0;
      o_Tx_Byte  <= '0;
      dv         <= 1'b0;
      timer      <= '0;
      gap_cnt    <= '0;
      o_Ack      <= '0;
      o_Done     <= '0;
      o_Err      <= 1'b0;
      o_Err_Id   <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      o_Grant_Id <= grant_next;
      o_Tx_Byte  <= byte_next;
      dv         <= dv_next;
      timer      <= timer_next;
      gap_cnt    <= gap_next;
      o_Ack      <= ack_next;
      o_Done     <= done_next;
      o_Err      <= err_next;
      o_Err_Id   <= err_id_next;
    end
  end

  // Gated so DV is already low in the cycle the transmitter reports done.
  assign o_Tx_DV = dv & ~i_Tx_Done;
  assign o_Busy  = (state == S_SEND) || (state == S_GAP);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: randomized round-robin / timeout bench for the arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int TIMEOUT_CLKS = 52;
  localparam int GAP_CLKS     = 2;
  localparam int FRAME_CLKS   = 11 * CLKS_PER_BIT;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [3:0]  i_Req;
  logic [31:0] i_Req_Byte;
  logic [3:0]  o_Ack;
  logic [3:0]  o_Done;
  logic        o_Err;
  logic [1:0]  o_Err_Id;
  logic        o_Busy;
  logic [1:0]  o_Grant_Id;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;

  int n_checks = 0;
  int n_errors = 0;
  int ptr;          // model round-robin pointer
  int last_err_id;  // model of the held error id

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CLKS_PER_BIT),
    .TIMEOUT_CLKS(TIMEOUT_CLKS), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req(i_Req), .i_Req_Byte(i_Req_Byte),
    .o_Ack(o_Ack), .o_Done(o_Done), .o_Err(o_Err), .o_Err_Id(o_Err_Id),
    .o_Busy(o_Busy), .o_Grant_Id(o_Grant_Id), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: first requester at or after pointer+1, wrapping.
  function automatic int rr_pick(input int p, input logic [3:0] pat);
    int id;
    for (int i = 1; i <= NUM_REQ; i++) begin
      id = (p + i) % NUM_REQ;
      if (pat[id[1:0]]) return id;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  // One full transaction from an idle arbiter; done_at > TIMEOUT_CLKS-1 means no done.
  task automatic serve(input logic [3:0] pat, input int done_at, input bit keep, input bit scramble);
    int          win;
    int          k;
    bit          finished;
    logic [7:0]  exp_byte;
    i_Req     = pat;
    i_Tx_Done = 1'b0;
    win       = rr_pick(ptr, pat);
    exp_byte  = i_Req_Byte[8*win +: 8];
    step();
    check_eq("ack", 32'(o_Ack), 32'(1) << win);
    check_eq("grant_id", 32'(o_Grant_Id), 32'(win));
    check_eq("tx_byte", 32'(o_Tx_Byte), 32'(exp_byte));
    check_eq("busy_send", 32'(o_Busy), 32'd1);
    ptr = win;
    if (!keep) i_Req = pat & ~(4'(1) << win);
    if (scramble) i_Req_Byte = $urandom;
    i_Tx_Active = 1'b1;
    k = 0;
    finished = 1'b0;
    while (!finished && k < 200) begin
      i_Tx_Done = (k == done_at);
      #1;
      check_eq("tx_dv", 32'(o_Tx_DV), (k == done_at) ? 32'd0 : 32'd1);
      step();
      k++;
      i_Tx_Done = 1'b0;
      if (o_Done != 4'd0 || o_Err) finished = 1'b1;
    end
    i_Tx_Active = 1'b0;
    if (done_at <= TIMEOUT_CLKS - 1) begin
      check_eq("done", 32'(o_Done), 32'(1) << win);
      check_eq("no_err", 32'(o_Err), 32'd0);
      check_eq("done_latency", 32'(k), 32'(done_at + 1));
    end else begin
      last_err_id = win;
      check_eq("err", 32'(o_Err), 32'd1);
      check_eq("no_done_on_err", 32'(o_Done), 32'd0);
      check_eq("err_latency", 32'(k), 32'(TIMEOUT_CLKS));
    end
    check_eq("err_id", 32'(o_Err_Id), 32'(last_err_id));
    check_eq("byte_held", 32'(o_Tx_Byte), 32'(exp_byte));
    check_eq("gap_dv", 32'(o_Tx_DV), 32'd0);
    check_eq("gap_busy", 32'(o_Busy), 32'd1);
    // Requests and done strobes during the gap must be ignored.
    i_Req     = 4'($urandom_range(1, 15));
    i_Tx_Done = 1'b1;
    for (int g = 1; g < GAP_CLKS; g++) begin
      step();
      check_eq("gap_busy_hold", 32'(o_Busy), 32'd1);
      check_eq("gap_no_ack", 32'(o_Ack), 32'd0);
      check_eq("gap_pulses", 32'({o_Done, o_Err}), 32'd0);
    end
    step();
    check_eq("idle_busy", 32'(o_Busy), 32'd0);
    check_eq("idle_no_ack", 32'(o_Ack), 32'd0);
    check_eq("idle_pulses", 32'({o_Done, o_Err}), 32'd0);
    check_eq("idle_dv", 32'(o_Tx_DV), 32'd0);
    i_Tx_Done = 1'b0;
  endtask

  task automatic check_quiet(input int cycles);
    i_Req = 4'd0;
    for (int c = 0; c < cycles; c++) begin
      step();
      check_eq("quiet_ack", 32'(o_Ack), 32'd0);
      check_eq("quiet_busy", 32'(o_Busy), 32'd0);
    end
  endtask

  initial begin
    int da;
    i_Reset     = 1'b1;
    i_Req       = 4'd0;
    i_Req_Byte  = 32'd0;
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    ptr         = NUM_REQ - 1;
    last_err_id = 0;
    step();
    step();
    check_eq("rst_outputs", 32'({o_Ack, o_Done, o_Err, o_Err_Id, o_Busy, o_Grant_Id, o_Tx_DV}), 32'd0);
    check_eq("rst_tx_byte", 32'(o_Tx_Byte), 32'd0);
    i_Reset = 1'b0;
    check_quiet(3);

    // Single request, then no repeat frame.
    i_Req_Byte = 32'h0000_00A5;
    serve(4'b0001, FRAME_CLKS, 1'b0, 1'b0);
    check_quiet(5);

    // All four requesting continuously.
    i_Req_Byte = 32'h1312_1110;
    for (int r = 0; r < 5; r++) serve(4'b1111, FRAME_CLKS, 1'b1, 1'b0);

    // Fairness wrap: grant 2, then 0101 serves 0 then 2.
    serve(4'b0100, FRAME_CLKS, 1'b0, 1'b1);
    serve(4'b0101, FRAME_CLKS, 1'b1, 1'b1);
    serve(4'b0101, FRAME_CLKS, 1'b1, 1'b1);

    // Timeout, then done coinciding with the last timeout cycle.
    i_Req_Byte = $urandom;
    serve(4'b0010, 1000, 1'b0, 1'b1);
    serve(4'b1000, TIMEOUT_CLKS - 1, 1'b0, 1'b1);

    // Randomized traffic, mixing normal frames, early dones and timeouts.
    for (int t = 0; t < 30; t++) begin
      i_Req_Byte = $urandom;
      case ($urandom_range(0, 3))
        0:       da = $urandom_range(0, TIMEOUT_CLKS + 8);
        default: da = FRAME_CLKS;
      endcase
      serve(4'($urandom_range(1, 15)), da, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset while mid-frame.
    i_Req = 4'b0100;
    da = rr_pick(ptr, 4'b0100);
    step();
    check_eq("mid_ack", 32'(o_Ack), 32'(1) << da);
    i_Req = 4'd0;
    i_Tx_Active = 1'b1;
    repeat (18) @(posedge i_Clock);
    #3;
    i_Reset = 1'b1;
    #1;
    check_eq("mid_rst_dv", 32'(o_Tx_DV), 32'd0);
    check_eq("mid_rst_pulses", 32'({o_Ack, o_Done, o_Err}), 32'd0);
    check_eq("mid_rst_busy", 32'(o_Busy), 32'd0);
    step();
    i_Reset     = 1'b0;
    i_Tx_Active = 1'b0;
    ptr         = NUM_REQ - 1;
    last_err_id = 0;
    i_Req_Byte  = $urandom;
    serve(4'b1111, FRAME_CLKS, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx instance between NUM_REQ byte producers. It accepts byte requests, grants one at a time, and drives the transmitter's i_Tx_DV / i_Tx_Byte. It holds DV for the full frame and releases it on completion. A per-frame timeout watchdog aborts a hung frame, and the block guarantees an idle gap so the transmitter never re-sends a byte.

Parameters:
NUM_REQ, 4, number of requesters (2..8); grant index width IDW = clog2(NUM_REQ).
CLKS_PER_BIT, 87, clocks per UART bit; must match the uart_tx instance.
TIMEOUT_CLKS, 13*CLKS_PER_BIT, max cycles in SEND before abort (frame is 11 bits: start, 8 data, parity, stop).
GAP_CLKS, 2, cycles DV is held low after each frame or abort; minimum 1.

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Req  in  NUM_REQ  per-requester "byte pending" level
i_Req_Byte  in  8*NUM_REQ  requester k byte on bits [8k+7:8k]
o_Ack  out  NUM_REQ  one-cycle pulse: requester's byte latched; requester may change byte/drop Req
o_Done  out  NUM_REQ  one-cycle pulse: that requester's frame completed
o_Err  out  1  one-cycle pulse: frame aborted by timeout
o_Err_Id  out  IDW  requester id of aborted frame, held until next abort
o_Busy  out  1  high in SEND and GAP
o_Grant_Id  out  IDW  id of current/last grant
o_Tx_DV  out  1  to uart_tx i_Tx_DV
o_Tx_Byte  out  8  to uart_tx i_Tx_Byte, stable for whole SEND
i_Tx_Active  in  1  from uart_tx o_Tx_Active (status only, not used for sequencing)
i_Tx_Done  in  1  from uart_tx o_Tx_Done

Behaviour:
- Reset (async, i_Reset=1): state IDLE, all outputs 0, o_Tx_Byte=0, timer=0, RR pointer=NUM_REQ-1 so requester 0 has first priority.
- States: IDLE, SEND, GAP (2-bit encoding; unused codes go to IDLE).
- IDLE: o_Tx_DV=0, o_Busy=0.
  - If any i_Req bit is set at an edge, select the first set bit searching from (pointer+1) mod NUM_REQ upward with wrap.
  - At that edge: latch the byte into o_Tx_Byte, set o_Grant_Id and pointer to the winner, pulse o_Ack[winner], set timer=0, go to SEND.
  - Latency: o_Ack, o_Tx_DV and o_Busy are high the cycle after the edge at which i_Req was sampled.
- SEND: DV register = 1; timer increments each cycle.
  - o_Tx_DV = DV register AND NOT i_Tx_Done (combinational gating). DV must be low in the same cycle the transmitter reports done, so it does not restart.
  - i_Tx_Done=1: pulse o_Done[grant], timer=0, go to GAP.
  - Else if timer == TIMEOUT_CLKS-1: pulse o_Err, o_Err_Id=grant, DV=0, timer=0, go to GAP. No o_Done for that requester.
  - If i_Tx_Done and the timeout occur in the same cycle, i_Tx_Done wins.
- GAP: o_Tx_DV=0; count GAP_CLKS cycles, then go to IDLE. Requests are not sampled in GAP.
- A requester still asserting i_Req after its o_Ack is a new request (next byte). Round-robin guarantees other pending requesters are served first.
- i_Req drop before grant: the request is withdrawn silently. Changes to i_Req_Byte after o_Ack do not affect the frame in flight.
- i_Tx_Done outside SEND is ignored.
- Reset mid-frame: DV drops immediately (async), which returns uart_tx to idle; no o_Done or o_Err pulse.
- Timer width: clog2(TIMEOUT_CLKS+1); no wrap is possible.
- o_Ack, o_Done and o_Err are registered single-cycle pulses; at most one bit of o_Ack/o_Done is set per cycle.

Test Plan:
- Single request, CLKS_PER_BIT=4, GAP_CLKS=2: i_Req=0001, byte0=0xA5 -> o_Ack=0001 one cycle later; o_Tx_DV high; uart_tx emits 0xA5 with parity 0; o_Done=0001 once; DV low for 2 cycles; no second frame.
- All four requesting continuously, bytes 0x10..0x13 -> grant order 0,1,2,3,0,1...; each id gets exactly one o_Ack per round; serial stream 0x10,0x11,0x12,0x13,0x10.
- Fairness wrap: grant=2, then i_Req=0101 -> next grant is id 0 (search 3,0), then id 2.
- Timeout: i_Tx_Done tied 0, TIMEOUT_CLKS=52 -> o_Err pulses 52 cycles after entering SEND, o_Err_Id=grant, DV low, no o_Done; the next request is served after the gap.
- Done/timeout coincide: drive i_Tx_Done=1 on cycle timer=51 -> o_Done pulses, o_Err stays 0.
- Reset mid-frame: assert i_Reset while bit 4 is on the line -> o_Tx_DV=0 immediately, all pulses 0, pointer=NUM_REQ-1; after release with i_Req=1111 -> id 0 is granted first.
